lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer between the execute stage and the word-addressed, synchronous-read data memory. Accepts one byte-addressed load or store per handshake and drives byte write enables and shifted store data. Splits accesses that cross a word boundary into two memory beats and merges, aligns and sign/zero-extends load data. Returns one registered response per request.

## Interface

- DATA_WIDTH, 32: data word width; only 32 is supported.
- ADDR_WIDTH, 32: byte address width of requests.
- MEM_AW, 14: word address width of the data memory.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_func  input  3  funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  DATA_WIDTH  store data, right-aligned.
- resp_valid  output  1  one-cycle pulse, request complete.
- resp_rdata  output  DATA_WIDTH  extended load result; 0 for stores.
- mem_en  output  1  memory access enable (registered).
- mem_addr  output  MEM_AW  word address (registered).
- mem_we  output  4  byte write enables; 0 for reads (registered).
- mem_din  output  DATA_WIDTH  shifted write data (registered).
- mem_dout  input  DATA_WIDTH  read data, valid the cycle after mem_en.

## Operation

- Accept when req_valid && req_ready. Latch we, func, addr, wdata. Let off = addr[1:0] and w0 = addr[MEM_AW+1:2].
- Access size: func[1:0] 0 = byte, 1 = half, any other value = word. Loads: func[2] selects zero-extend; func 3/6/7 behave as LW.
- Split condition: half with off==3, or word with off!=0. Beat 2 uses w0+1 modulo 2^MEM_AW, so all-ones wraps to 0.
- Store byte mask m = size mask (0001/0011/1111) << off, computed 8 bits wide.
  - Beat 1: mem_we = m[3:0], mem_din = wdata << 8*off.
  - Beat 2: mem_we = m[7:4], mem_din = wdata >> (32-8*off).
- Load merge: lo = beat1 >> 8*off. If split, hi = beat2 << (32-8*off). merged = lo | hi. Result = merged extended per size and func[2].
- FSM states, in order:
  - IDLE: on accept, go to BEAT1.
  - BEAT1: issue beat 1. Go to BEAT2 if split, else to RESP for stores or WAIT for loads.
  - BEAT2: issue beat 2; capture beat-1 read data if a load. Go to RESP for stores, WAIT for loads.
  - WAIT: capture final read data. Go to RESP.
  - RESP: resp_valid=1 with final rdata. Go to IDLE.
- mem_en/mem_we are high only in the cycle of each issued beat. The memory never stalls.
- Reset at any point: go to IDLE and discard any in-flight request (a beat already written stays written).

## Timing

- Reset values: req_ready=1 (IDLE); resp_valid=0, resp_rdata=0, mem_en=0, mem_addr=0, mem_we=0, mem_din=0.
- Accept edge ends cycle N. Beat 1 appears in cycle N+1; a split beat 2 appears in N+2.
- resp_valid: aligned store N+2; split store N+3; aligned load N+3; split load N+4.
- req_ready goes low from N+1 and returns high the cycle after RESP. Back-to-back requests are therefore spaced 3–5 cycles apart.
- resp_rdata is held from RESP until the next RESP; it is valid only with resp_valid.

## Structure

- funct3 constants come from the shared opcode header.
- FSM state encoding and the size codes are localparams in this block.
- One combinational sub-module, lsu_align, holds the store shift/byte-mask generation and the load merge/extend. lsu_ctrl contains the FSM, latches and registered memory outputs.

## Test plan

- SW 0xDEADBEEF @0x100: N+1 mem_addr=0x40, mem_we=1111, mem_din=0xDEADBEEF; resp_valid at N+2.
- LB @0x103, word 0x80FF1234: resp_rdata=0xFFFFFF80 at N+3. LBU at the same address returns 0x00000080.
- LH @0x203, words[0x80]=0xAB000000, [0x81]=0x000000CD: mem_addr 0x80 then 0x81; resp_rdata=0xFFFFCDAB at N+4.
- SW 0x11223344 @0x102: beat 1 we=1100, din=0x33440000 at 0x40; beat 2 we=0011, din=0x00001122 at 0x41.
- Split LW at word 0x3FFF, off=1: beat 2 mem_addr=0x0000.
- rst asserted in BEAT2 of a split load: next cycle IDLE, no resp_valid, req_ready=1, mem_en=0.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, access
// sizes, FSM states and a helper that decodes funct3 into an access size.
package lsu_ctrl_pkg;

  // funct3 codes for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT1,
    S_BEAT2,
    S_WAIT,
    S_RESP
  } state_t;

  // func[1:0] 0 = byte, 1 = half, anything else = word
  function automatic size_t size_of(input logic [2:0] func);
    case (func[1:0])
      2'd0:    return SZ_BYTE;
      2'd1:    return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path for the load/store sequencer.
//   func, off      : funct3 and byte offset of the access
//   wdata          : right-aligned store data
//   rd_first       : captured read data of beat 1 (used only when split)
//   rd_last        : read data of the final beat
//   split          : access crosses a word boundary (two beats)
//   we1/we2        : byte enables of beat 1 / beat 2
//   din1/din2      : shifted store data of beat 1 / beat 2
//   rdata          : merged, aligned and extended load result
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            func,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rd_first,
  input  logic [DATA_WIDTH-1:0] rd_last,
  output logic                  split,
  output logic [3:0]            we1,
  output logic [3:0]            we2,
  output logic [DATA_WIDTH-1:0] din1,
  output logic [DATA_WIDTH-1:0] din2,
  output logic [DATA_WIDTH-1:0] rdata
);

  size_t                 size;
  logic [7:0]            mask;
  logic [5:0]            sh_lo;
  logic [5:0]            sh_hi;
  logic [DATA_WIDTH-1:0] lo_word;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    size  = size_of(func);
    sh_lo = {1'b0, off, 3'b000};
    // off == 0 gives a 32-bit shift, which clears the upper-beat terms
    sh_hi = 6'd32 - sh_lo;

    case (size)
      SZ_BYTE: mask = 8'h01;
      SZ_HALF: mask = 8'h03;
      default: mask = 8'h0F;
    endcase
    mask = mask << off;

    split = (size == SZ_HALF && off == 2'd3) || (size == SZ_WORD && off != 2'd0);
    we1   = mask[3:0];
    we2   = mask[7:4];
    din1  = wdata << sh_lo;
    din2  = wdata >> sh_hi;

    // a split load's first word was captured earlier; otherwise it is the last read
    lo_word = split ? rd_first : rd_last;
    merged  = lo_word >> sh_lo;
    if (split) merged = merged | (rd_last << sh_hi);

    case (size)
      SZ_BYTE: rdata = {{24{~func[2] & merged[7]}}, merged[7:0]};
      SZ_HALF: rdata = {{16{~func[2] & merged[15]}}, merged[15:0]};
      default: rdata = merged;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and a word-addressed synchronous-read
// data memory. One byte-addressed request per handshake; word-crossing
// accesses take two memory beats; one response pulse per request.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_we/func/addr/wdata  : request fields
//   resp_valid/resp_rdata   : completion pulse and extended load data
//   mem_en/addr/we/din      : registered memory command
//   mem_dout                : memory read data, valid the cycle after mem_en
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_AW     = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_func,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_en,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [3:0]            mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  state_t                state_q, state_d;
  logic                  we_q;
  logic [2:0]            func_q;
  logic [1:0]            off_q;
  logic [MEM_AW-1:0]     w0_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] beat1_q;

  logic                  cur_we;
  logic [2:0]            cur_func;
  logic [1:0]            cur_off;
  logic [MEM_AW-1:0]     cur_w0;
  logic [DATA_WIDTH-1:0] cur_wdata;

  logic                  split;
  logic [3:0]            we1, we2;
  logic [DATA_WIDTH-1:0] din1, din2, rdata;
  logic                  unused_addr;

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:MEM_AW+2];

  // In IDLE the live request feeds the aligner so beat 1 is registered on the
  // accept edge itself; afterwards the latched copy is used.
  always_comb begin
    if (req_ready) begin
      cur_we    = req_we;
      cur_func  = req_func;
      cur_off   = req_addr[1:0];
      cur_w0    = req_addr[MEM_AW+1:2];
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_func  = func_q;
      cur_off   = off_q;
      cur_w0    = w0_q;
      cur_wdata = wdata_q;
    end
  end

  lsu_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .func     (cur_func),
    .off      (cur_off),
    .wdata    (cur_wdata),
    .rd_first (beat1_q),
    .rd_last  (mem_dout),
    .split    (split),
    .we1      (we1),
    .we2      (we2),
    .din1     (din1),
    .din2     (din2),
    .rdata    (rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_BEAT1;
      S_BEAT1: begin
        if (split)     state_d = S_BEAT2;
        else if (we_q) state_d = S_RESP;
        else           state_d = S_WAIT;
      end
      S_BEAT2: state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      func_q     <= '0;
      off_q      <= '0;
      w0_q       <= '0;
      wdata_q    <= '0;
      beat1_q    <= '0;
      resp_rdata <= '0;
      mem_en     <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= '0;
      mem_din    <= '0;
    end else begin
      state_q <= state_d;
      mem_en  <= 1'b0;
      mem_we  <= '0;

      if (state_q == S_IDLE && req_valid) begin
        we_q     <= req_we;
        func_q   <= req_func;
        off_q    <= req_addr[1:0];
        w0_q     <= req_addr[MEM_AW+1:2];
        wdata_q  <= req_wdata;
        mem_en   <= 1'b1;
        mem_addr <= cur_w0;
        mem_we   <= cur_we ? we1 : 4'h0;
        mem_din  <= cur_we ? din1 : '0;
      end

      if (state_q == S_BEAT1 && split) begin
        mem_en   <= 1'b1;
        mem_addr <= w0_q + 1'b1;
        mem_we   <= we_q ? we2 : 4'h0;
        mem_din  <= we_q ? din2 : '0;
      end

      if (state_q == S_BEAT2 && !we_q) beat1_q <= mem_dout;

      if (state_d == S_RESP) resp_rdata <= we_q ? '0 : rdata;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic [13:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_AW(14)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func   (req_func),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Data memory environment: word array, synchronous read, byte write enables
  logic [31:0] tbmem [0:16383] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) tbmem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      mem_dout <= tbmem[mem_addr];
    end
  end

  // Reference model: flat byte-addressed memory over the 16-bit address space
  logic [7:0] ref_mem [0:65535] = '{default: 8'h0};

  function automatic int sz_bytes(input logic [2:0] f);
    case (f[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_split(input logic [2:0] f, input logic [31:0] a);
    return (int'(a[1:0]) + sz_bytes(f)) > 4;
  endfunction

  function automatic void model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    logic [15:0] ba;
    for (int i = 0; i < sz_bytes(f); i++) begin
      ba = a[15:0] + 16'(i);
      ref_mem[ba] = wd[8*i +: 8];
    end
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
    int          n = sz_bytes(f);
    logic [31:0] v = '0;
    logic [15:0] ba;
    for (int i = 0; i < n; i++) begin
      ba = a[15:0] + 16'(i);
      v[8*i +: 8] = ref_mem[ba];
    end
    if (n < 4 && !f[2] && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result of the last transaction
  int          got_lat;
  logic [31:0] got_rdata;
  int          nbeats;
  int          bt_cyc  [4];
  logic [13:0] bt_addr [4];
  logic [3:0]  bt_we   [4];
  logic [31:0] bt_din  [4];

  // Called #1 after a rising edge. Cycle numbers count from the accept edge (cycle 1 = N+1).
  task automatic run_req(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_func = f; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_func = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    nbeats = 0; got_lat = 0; got_rdata = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_en && nbeats < 4) begin
        bt_cyc[nbeats] = c; bt_addr[nbeats] = mem_addr;
        bt_we[nbeats] = mem_we; bt_din[nbeats] = mem_din;
        nbeats++;
      end
      if (resp_valid) begin
        got_lat = c; got_rdata = resp_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (got_lat == 0) begin
      check("resp_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      check("post_resp_ready", {30'h0, req_ready, resp_valid}, 32'd2);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          nb;
    logic [13:0] a0;
    logic [3:0]  we0;
    logic [31:0] d0;
    logic [13:0] a1;
    logic [3:0]  we1;
    logic [31:0] d1;
  } vec_t;

  vec_t vec [14];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0]  = '{1'b1, F3_SW,  32'h00000100, 32'hDEADBEEF, 32'h0,        2, 1, 14'h0040, 4'hF, 32'hDEADBEEF, 14'h0,    4'h0, 32'h0};
    vec[1]  = '{1'b1, F3_SW,  32'h00000100, 32'h80FF1234, 32'h0,        2, 1, 14'h0040, 4'hF, 32'h80FF1234, 14'h0,    4'h0, 32'h0};
    vec[2]  = '{1'b0, F3_LB,  32'h00000103, 32'h0,        32'hFFFFFF80, 3, 1, 14'h0040, 4'h0, 32'h0,        14'h0,    4'h0, 32'h0};
    vec[3]  = '{1'b0, F3_LBU, 32'h00000103, 32'h0,        32'h00000080, 3, 1, 14'h0040, 4'h0, 32'h0,        14'h0,    4'h0, 32'h0};
    vec[4]  = '{1'b1, F3_SW,  32'h00000200, 32'hAB000000, 32'h0,        2, 1, 14'h0080, 4'hF, 32'hAB000000, 14'h0,    4'h0, 32'h0};
    vec[5]  = '{1'b1, F3_SW,  32'h00000204, 32'h000000CD, 32'h0,        2, 1, 14'h0081, 4'hF, 32'h000000CD, 14'h0,    4'h0, 32'h0};
    vec[6]  = '{1'b0, F3_LH,  32'h00000203, 32'h0,        32'hFFFFCDAB, 4, 2, 14'h0080, 4'h0, 32'h0,        14'h0081, 4'h0, 32'h0};
    vec[7]  = '{1'b1, F3_SW,  32'h00000102, 32'h11223344, 32'h0,        3, 2, 14'h0040, 4'hC, 32'h33440000, 14'h0041, 4'h3, 32'h00001122};
    vec[8]  = '{1'b0, F3_LW,  32'h00000102, 32'h0,        32'h11223344, 4, 2, 14'h0040, 4'h0, 32'h0,        14'h0041, 4'h0, 32'h0};
    vec[9]  = '{1'b1, F3_SW,  32'h0000FFFD, 32'hCAFEF00D, 32'h0,        3, 2, 14'h3FFF, 4'hE, 32'hFEF00D00, 14'h0000, 4'h1, 32'h000000CA};
    vec[10] = '{1'b0, F3_LW,  32'hABCDFFFD, 32'h0,        32'hCAFEF00D, 4, 2, 14'h3FFF, 4'h0, 32'h0,        14'h0000, 4'h0, 32'h0};
    vec[11] = '{1'b0, F3_LHU, 32'h00000203, 32'h0,        32'h0000CDAB, 4, 2, 14'h0080, 4'h0, 32'h0,        14'h0081, 4'h0, 32'h0};
    vec[12] = '{1'b1, F3_SB,  32'h00000101, 32'h12345678, 32'h0,        2, 1, 14'h0040, 4'h2, 32'h34567800, 14'h0,    4'h0, 32'h0};
    vec[13] = '{1'b0, F3_LH,  32'h00000102, 32'h0,        32'h00003344, 3, 1, 14'h0040, 4'h0, 32'h0,        14'h0,    4'h0, 32'h0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_func = 3'h0; req_addr = 32'h0; req_wdata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata,      32'h0);
    check("rst_mem_en",     32'(mem_en),     32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'h0);
    check("rst_mem_we",     32'(mem_we),     32'h0);
    check("rst_mem_din",    mem_din,         32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      run_req(vec[i].we, vec[i].f, vec[i].addr, vec[i].wdata);
      check($sformatf("v%0d_lat", i),    32'(got_lat), 32'(vec[i].lat));
      check($sformatf("v%0d_rdata", i),  got_rdata,    vec[i].rdata);
      check($sformatf("v%0d_nbeats", i), 32'(nbeats),  32'(vec[i].nb));
      check($sformatf("v%0d_b0_cyc", i),  32'(bt_cyc[0]),  32'd1);
      check($sformatf("v%0d_b0_addr", i), 32'(bt_addr[0]), 32'(vec[i].a0));
      check($sformatf("v%0d_b0_we", i),   32'(bt_we[0]),   32'(vec[i].we0));
      if (vec[i].we) check($sformatf("v%0d_b0_din", i), bt_din[0], vec[i].d0);
      if (vec[i].nb == 2) begin
        check($sformatf("v%0d_b1_cyc", i),  32'(bt_cyc[1]),  32'd2);
        check($sformatf("v%0d_b1_addr", i), 32'(bt_addr[1]), 32'(vec[i].a1));
        check($sformatf("v%0d_b1_we", i),   32'(bt_we[1]),   32'(vec[i].we1));
        if (vec[i].we) check($sformatf("v%0d_b1_din", i), bt_din[1], vec[i].d1);
      end
      if (vec[i].we) model_store(vec[i].f, vec[i].addr, vec[i].wdata);
    end

    // Reset during BEAT2 of a split load discards the request
    begin
      bit seen = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_func = F3_LW; req_addr = 32'h00000102;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("rstmid_beat2_en", {31'h0, mem_en}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
      check("rstmid_req_ready",  32'(req_ready),  32'd1);
      check("rstmid_mem_en",     32'(mem_en),     32'd0);
      check("rstmid_resp_rdata", resp_rdata,      32'h0);
      for (int c = 0; c < 6; c++) begin
        seen = seen | resp_valid;
        @(posedge clk); #1;
      end
      check("rstmid_no_resp", {31'h0, seen}, 32'd0);
    end

    // Randomized traffic against the byte-level model
    for (int k = 0; k < 300; k++) begin
      logic        we;
      logic [2:0]  f;
      logic [31:0] a, wd, exp_rd;
      int          exp_lat;
      bit          sp;
      we = 1'($urandom);
      f  = 3'($urandom);
      a  = ($urandom & 32'hFFFF0000) | (32'($urandom_range(0, 1)) ? 32'h0000FFE0 : 32'h00000100)
           + 32'($urandom_range(0, 63));
      a  = {$urandom >> 16, a[15:0]};
      wd = $urandom;
      sp = model_split(f, a);
      exp_lat = 2 + (sp ? 1 : 0) + (we ? 0 : 1);
      exp_rd  = we ? 32'h0 : model_load(f, a);
      run_req(we, f, a, wd);
      check($sformatf("r%0d_lat", k),    32'(got_lat), 32'(exp_lat));
      check($sformatf("r%0d_nbeats", k), 32'(nbeats),  sp ? 32'd2 : 32'd1);
      check($sformatf("r%0d_rdata", k),  got_rdata,    exp_rd);
      if (we) model_store(f, a, wd);
    end

    // Memory contents versus the model
    begin
      int words [];
      words = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9,
                32'h3FF8, 32'h3FF9, 32'h3FFA, 32'h3FFB, 32'h3FFC, 32'h3FFD, 32'h3FFE, 32'h3FFF,
                32'h40, 32'h41, 32'h42, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h51, 32'h80, 32'h81};
      foreach (words[j]) begin
        logic [31:0] exp_w;
        logic [15:0] ba;
        for (int b = 0; b < 4; b++) begin
          ba = 16'(words[j] * 4 + b);
          exp_w[8*b +: 8] = ref_mem[ba];
        end
        check($sformatf("mem_%0h", words[j]), tbmem[words[j]], exp_w);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
